// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment digit encoder.
package seg7_pkg;

  // Segment patterns indexed by hex digit; bit0..6 = a..g, bit7 (dp) never set here.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  localparam logic [7:0]  SEG_DASH  = 8'h40;
  localparam logic [7:0]  SEG_BLANK = 8'h00;
  localparam logic [31:0] DEC_MAX   = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ENCODE
  } state_t;

  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg7_dabble_step.sv
// One double-dabble correction: add 3 to every BCD nibble that is 5 or more.
module seg7_dabble_step #(
  parameter int NIB = 8
) (
  input  logic [NIB-1:0][3:0] bcd_in,
  output logic [NIB-1:0][3:0] bcd_out
);

  for (genvar g = 0; g < NIB; g++) begin : g_nib
    assign bcd_out[g] = (bcd_in[g] >= 4'd5) ? bcd_in[g] + 4'd3 : bcd_in[g];
  end

endmodule

// File: rtl/seg7_digit_encoder.sv
// Converts a 32-bit value to eight hex/decimal segment bytes for the
// multiplexed display driver; decimal uses a 32-cycle double-dabble.
module seg7_digit_encoder
  import seg7_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int VAL_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VAL_W-1:0]      in_value,
  input  logic                  in_dec,
  input  logic                  in_blank,
  input  logic [DIGITS-1:0]     in_dp,
  output logic [8*DIGITS-1:0]   numbers,
  output logic                  out_update
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SR_W   = BCD_W + VAL_W;
  localparam int ITER_W = $clog2(VAL_W);

  state_t               state, state_nx;
  logic [VAL_W-1:0]     val_q;
  logic                 dec_q, blank_q, ovf_q;
  logic [DIGITS-1:0]    dp_q;
  logic [SR_W-1:0]      sr;
  logic [ITER_W-1:0]    iter;
  logic [BCD_W-1:0]     bcd_adj;
  logic                 accept;
  logic                 last_iter;

  logic [DIGITS-1:0][3:0] digit;
  logic [DIGITS-1:0][7:0] enc;
  logic                   zrun;

  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (iter == ITER_W'(VAL_W - 1));

  seg7_dabble_step #(.NIB(DIGITS)) u_step (
    .bcd_in  (sr[SR_W-1 -: BCD_W]),
    .bcd_out (bcd_adj)
  );

  // Next-state: decimal in range iterates, everything else encodes directly.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (in_dec && (in_value <= DEC_MAX)) ? CONV : ENCODE;
      CONV:    if (last_iter) state_nx = ENCODE;
      ENCODE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request latch and double-dabble shift register (adjust, then shift).
  always_ff @(posedge clk) begin
    if (accept) begin
      val_q   <= in_value;
      dec_q   <= in_dec;
      blank_q <= in_blank;
      dp_q    <= in_dp;
      ovf_q   <= in_dec && (in_value > DEC_MAX);
      sr      <= {{BCD_W{1'b0}}, in_value};
      iter    <= '0;
    end else if (state == CONV) begin
      sr      <= {bcd_adj, sr[VAL_W-1:0]} << 1;
      iter    <= iter + 1'b1;
    end
  end

  // Digit select, segment lookup, leading-zero blanking and dp merge.
  always_comb begin
    zrun  = 1'b1;
    digit = '0;
    enc   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit[i] = dec_q ? sr[VAL_W + 4*i +: 4] : val_q[4*i +: 4];
      zrun     = zrun && (digit[i] == 4'd0);
      if (ovf_q)                        enc[i] = SEG_DASH;
      else if (blank_q && zrun && i != 0) enc[i] = SEG_BLANK;
      else                              enc[i] = seg_of(digit[i]);
      enc[i][7] = enc[i][7] | dp_q[i];
    end
  end

  // Output register: written only in ENCODE, update pulse follows the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      numbers    <= '0;
      out_update <= 1'b0;
    end else begin
      out_update <= (state == ENCODE);
      if (state == ENCODE) numbers <= enc;
    end
  end

endmodule

// File: tb/tb_seg7_digit_encoder.sv
// Scoreboard bench for seg7_digit_encoder: expected patterns and write edges
// are queued at acceptance and retired when out_update pulses.
module tb_seg7_digit_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = '0;
  logic        in_dec = 1'b0;
  logic        in_blank = 1'b0;
  logic [7:0]  in_dp = '0;
  logic [63:0] numbers;
  logic        out_update;

  seg7_digit_encoder #(.DIGITS(8), .VAL_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_dec     (in_dec),
    .in_blank   (in_blank),
    .in_dp      (in_dp),
    .numbers    (numbers),
    .out_update (out_update)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SEGT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  typedef struct {
    logic [63:0] nums;
    int          wr;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        rst_at_edge = 1'b0;
  logic        prev_upd = 1'b0;
  logic [63:0] prev_nums = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: decimal digits by repeated division, not double-dabble.
  function automatic logic [63:0] model(input logic [31:0] v, input bit dec,
                                        input bit blank, input logic [7:0] dp);
    logic [3:0]  dg [8];
    logic [31:0] t;
    logic [7:0]  s;
    logic [63:0] r;
    int          msd;
    bit          ovf;
    ovf = dec && (v > 32'd99999999);
    t   = v;
    msd = 0;
    r   = '0;
    for (int i = 0; i < 8; i++) begin
      if (dec) begin dg[i] = 4'(t % 10); t = t / 10; end
      else     begin dg[i] = t[3:0];     t = t >> 4; end
    end
    for (int i = 0; i < 8; i++) if (dg[i] != 4'd0) msd = i;
    for (int i = 0; i < 8; i++) begin
      if (ovf)                  s = 8'h40;
      else if (blank && i > msd) s = 8'h00;
      else                      s = SEGT[dg[i]];
      s[7] = s[7] | dp[i];
      r[8*i +: 8] = s;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  // Retire expectations on each update pulse; also check hold and pulse width.
  always @(negedge clk) begin
    exp_t e;
    if (out_update) begin
      chk("upd_width", {63'd0, prev_upd}, 64'd0);
      if (q.size() == 0) begin
        chk("unexp_upd", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("numbers", numbers, e.nums);
        chk("wr_edge", 64'(cyc), 64'(e.wr));
      end
    end else if (rst_at_edge && numbers !== prev_nums) begin
      chk("hold", numbers, prev_nums);
    end
    prev_upd  = out_update;
    prev_nums = numbers;
  end

  task automatic send(input logic [31:0] v, input bit dec, input bit blank,
                      input logic [7:0] dp, input logic [63:0] exp,
                      input bit push, output int acc);
    int   budget;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    in_dec   = dec;
    in_blank = blank;
    in_dp    = dp;
    budget   = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      acc = -1;
    end else begin
      acc = cyc + 1;
      if (push) begin
        e.nums = exp;
        e.wr   = acc + ((dec && v <= 32'd99999999) ? 33 : 1);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int          acc, acc1, acc2, wait_cyc;
    logic [31:0] v;
    bit          d, b;
    logic [7:0]  dp;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_numbers", numbers, 64'h0);
    chk("rst_update", {63'd0, out_update}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Directed vectors with fixed expected patterns
    send(32'd12345678, 1'b1, 1'b0, 8'h00, 64'h065B4F666D7D077F, 1'b1, acc);
    send(32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 64'h5E79775E7C797971, 1'b1, acc);
    send(32'd42,       1'b1, 1'b1, 8'h00, 64'h000000000000665B, 1'b1, acc);
    send(32'd0,        1'b1, 1'b1, 8'h00, 64'h000000000000003F, 1'b1, acc);
    send(32'd100000000, 1'b1, 1'b0, 8'h01, 64'h40404040404040C0, 1'b1, acc);
    send(32'h0,        1'b0, 1'b0, 8'h04, 64'h3F3F3F3F3FBF3F3F, 1'b1, acc);
    send(32'd99999999, 1'b1, 1'b1, 8'hA0, model(32'd99999999, 1'b1, 1'b1, 8'hA0), 1'b1, acc);
    send(32'h00000F00, 1'b0, 1'b1, 8'h80, model(32'h00000F00, 1'b0, 1'b1, 8'h80), 1'b1, acc);
    send(32'hFFFFFFFF, 1'b1, 1'b1, 8'h00, model(32'hFFFFFFFF, 1'b1, 1'b1, 8'h00), 1'b1, acc);

    // Random mix of hex, decimal and overflow requests
    for (int k = 0; k < 10; k++) begin
      d  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      dp = 8'($urandom);
      v  = (d && $urandom_range(0, 3) != 0) ? ($urandom % 32'd100000000) : $urandom;
      if ($urandom_range(0, 2) == 0) v = v >> $urandom_range(4, 28);
      send(v, d, b, dp, model(v, d, b, dp), 1'b1, acc);
    end

    // Request held during a conversion waits for in_ready
    send(32'd87654321, 1'b1, 1'b0, 8'h00, model(32'd87654321, 1'b1, 1'b0, 8'h00), 1'b1, acc1);
    send(32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 64'h5E79775E7C797971, 1'b1, acc2);
    chk("hold_accept", 64'(acc2), 64'(acc1 + 34));

    // Let the queue drain before the abort test
    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 100) begin @(negedge clk); wait_cyc++; end
    chk("drain1", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);

    // Reset ten cycles into a decimal conversion: result must never appear
    send(32'd12345678, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0, acc);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("ready_in_rst", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    chk("abort_numbers", numbers, 64'h0);
    chk("abort_update", {63'd0, out_update}, 64'd0);
    #1 chk("ready_after_abort", {63'd0, in_ready}, 64'd1);
    repeat (40) @(negedge clk);
    chk("abort_still_zero", numbers, 64'h0);

    // Service resumes normally after the abort
    send(32'd7, 1'b1, 1'b1, 8'h02, model(32'd7, 1'b1, 1'b1, 8'h02), 1'b1, acc);
    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 100) begin @(negedge clk); wait_cyc++; end
    chk("drain2", 64'(q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seg7_digit_encoder.md
Name: seg7_digit_encoder

Overview:
Upstream feeder for the 8-digit multiplexed seven-segment driver. Accepts a 32-bit value with a valid/ready handshake and converts it to eight hex or decimal digits. Decimal conversion is an iterative double-dabble. The block encodes each digit into a segment byte and holds the packed 64-bit pattern stable on `numbers` until the next accepted request. The driver consumes `numbers` directly, inverts it, and scans it.

Parameters:
DIGITS, 8, number of display digits; `numbers` width is 8*DIGITS; only 8 is supported.
VAL_W, 32, input value width; also the double-dabble iteration count.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept; high only in IDLE and while rst_n=1
in_value  input  32  value to display
in_dec  input  1  1 = decimal, 0 = hex
in_blank  input  1  1 = blank leading zeros
in_dp  input  8  decimal-point mask; bit i lights the dp of digit i
numbers  output  64  byte i = segments of digit i (byte 0 = rightmost); bit0..6 = a..g, bit7 = dp; 1 = lit
out_update  output  1  one-cycle pulse in the cycle after `numbers` changes

Behaviour:
- Reset (rst_n=0 at a posedge):
  - state goes to IDLE; numbers = 64'h0; out_update = 0.
  - in_ready is forced 0 combinationally while rst_n=0.
  - Reset aborts any in-flight conversion; the aborted result is never written.
- Accept on the posedge where in_valid && in_ready; the request fields are latched at that edge.
- States: IDLE, CONV, ENCODE.
  - IDLE -> CONV when accepting with in_dec=1 and in_value <= 99_999_999.
  - IDLE -> ENCODE when accepting with in_dec=0, or with in_dec=1 and in_value > 99_999_999 (overflow flag latched).
  - CONV: 64-bit shift register {bcd[31:0], bin[31:0]}. Each cycle, add 3 to every BCD nibble >= 5, then shift the whole register left by 1. An iteration counter runs 0..31; after the 32nd iteration -> ENCODE.
  - ENCODE: one cycle. Writes `numbers`, asserts out_update for the following cycle, then -> IDLE.
- Latency, with acceptance at edge T:
  - Hex or overflow: `numbers` written at edge T+1.
  - Decimal: `numbers` written at edge T+33.
  - in_ready returns high in the cycle after the write; back-to-back requests are allowed from then.
- Digit source: hex mode uses in_value[4i+3:4i]; decimal mode uses bcd[4i+3:4i].
- Segment table (hex digit: byte):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Overflow: every digit shows 8'h40 ("-"). Blanking is ignored; in_dp is still ORed in.
- Blanking: when in_blank=1, every digit above the most-significant nonzero digit becomes 8'h00 before the dp is ORed in. Digit 0 is never blanked, so a value of 0 shows "0".
- dp: numbers[8i+7] = segment_bit7 | in_dp[i]. The table never sets bit7.
- `numbers` holds its value in every state other than the ENCODE write.
- in_valid while busy: ignored; the upstream must hold the request until in_ready.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry segment constant table;
  - SEG_DASH = 8'h40 and SEG_BLANK = 8'h00;
  - DEC_MAX = 32'd99_999_999;
  - the state enum {IDLE, CONV, ENCODE}.
- One natural sub-module, seg7_dabble_step: a combinational add-3 step over 8 nibbles, instantiated once and applied once per CONV cycle.
- Segment lookup and blanking stay inline.

Test Plan:
- Decimal 12345678, blank=0, dp=0 -> after 33 cycles numbers = 64'h065B4F666D7D077F; out_update high for exactly one cycle.
- Hex 32'hDEADBEEF, dec=0 -> at T+1 numbers = 64'h5E79775E7C797971.
- Decimal 42, blank=1 -> numbers = 64'h000000000000665B. Decimal 0, blank=1 -> numbers = 64'h000000000000003F.
- Decimal 100000000 (overflow), dp=8'h01 -> numbers = 64'h40404040404040C0 at T+1.
- Hex 0, blank=0, dp=8'h04 -> numbers = 64'h3F3F3F3F3FBF3F3F.
- Reset at cycle 10 of a decimal conversion -> numbers = 0, no out_update pulse; in_ready = 1 after release. In a separate run, hold in_valid with a new value during CONV -> it is not accepted until in_ready rises.
